// File: rtl/axis_pkt_pkg.sv
// Shared definitions for the AXI-Stream packet buffer: egress FSM state
// encoding, default geometry and small width helpers.
// Optional feature macro (see axis_pkt_buffer.sv): AXIS_PKT_BUFFER_CUT_THROUGH_EN
package axis_pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 12;
  localparam int DEF_MAX_PKT_LEN = 256;

  // Byte strobe lanes for a given data width.
  function automatic int strb_width(input int dw);
    return dw / 8;
  endfunction

  // One RAM entry holds {tlast, tstrb, tdata}.
  function automatic int entry_width(input int dw);
    return dw + (dw / 8) + 1;
  endfunction

  // Bits needed to count 0 .. n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_pkt_ram.sv
// Simple dual-port RAM: one write port and one registered read port.
// Contents are not reset. A read of the address being written in the same
// cycle returns the previous contents.
module axis_pkt_ram #(
  parameter int WIDTH = 37,
  parameter int AW    = 12
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];
  logic [WIDTH-1:0] r_rdata;

  // Write port and registered read port share the clock.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axis_pkt_buffer.sv
// Store-and-forward AXI-Stream packet buffer over a circular RAM.
// Ingress writes {tlast, tstrb, tdata}; egress only starts a packet once it
// is completely stored, and forces tlast every MAX_PKT_LEN words.
// Optional feature: define AXIS_PKT_BUFFER_CUT_THROUGH_EN to let egress start
// as soon as any word is stored (tvalid may then drop between handshakes
// when egress catches up with ingress).
module axis_pkt_buffer
  import axis_pkt_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int MAX_PKT_LEN = DEF_MAX_PKT_LEN
) (
  input  logic                       axis_aclk,
  input  logic                       axis_aresetn,
  input  logic                       s_axis_enable,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]    s_axis_tstrb,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]    m_axis_tstrb,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [ADDR_WIDTH:0]        level,
  output logic [ADDR_WIDTH:0]        pkt_count
);

  localparam int STRB_WIDTH  = strb_width(DATA_WIDTH);
  localparam int ENTRY_WIDTH = entry_width(DATA_WIDTH);
  localparam int DEPTH       = 1 << ADDR_WIDTH;
  localparam int PW          = ADDR_WIDTH + 1;
  localparam int CW          = cnt_width(MAX_PKT_LEN);

  if ((MAX_PKT_LEN < 1) || (MAX_PKT_LEN > DEPTH)) begin : g_bad_pkt_len
    $error("axis_pkt_buffer: MAX_PKT_LEN must be within 1..2**ADDR_WIDTH");
  end
  if ((DATA_WIDTH < 8) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_width
    $error("axis_pkt_buffer: DATA_WIDTH must be a non-zero multiple of 8");
  end

  logic                   r_ingress_on;
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_wr_ptr_d;
  logic [PW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_in_cnt;
  logic [PW-1:0]          r_level;
  logic [PW-1:0]          r_pkt_count;
  state_t                 r_state;
  logic                   r_tvalid;
  logic                   r_tlast;
  logic [STRB_WIDTH-1:0]  r_tstrb;
  logic [DATA_WIDTH-1:0]  r_tdata;

  logic                   w_full;
  logic                   w_s_ready;
  logic                   w_accept;
  logic                   w_force_last;
  logic                   w_last_in;
  logic [ENTRY_WIDTH-1:0] w_wentry;
  logic                   w_send;
  logic                   w_pkt_in;
  logic                   w_pkt_out;
  logic [ENTRY_WIDTH-1:0] w_rentry;
  logic                   w_q_last;
  logic [STRB_WIDTH-1:0]  w_q_strb;
  logic [DATA_WIDTH-1:0]  w_q_data;
  logic [PW-1:0]          w_ahead;
  logic                   w_q_ok;
  logic                   w_start;
  logic                   w_more;
  logic                   w_chain;
  logic [PW-1:0]          w_raddr;

  assign w_full       = (r_level == PW'(DEPTH));
  assign w_s_ready    = r_ingress_on && s_axis_enable && !w_full;
  assign w_accept     = s_axis_tvalid && w_s_ready;
  assign w_force_last = (r_in_cnt == CW'(MAX_PKT_LEN - 1));
  assign w_last_in    = s_axis_tlast || w_force_last;
  assign w_wentry     = {w_last_in, s_axis_tstrb, s_axis_tdata};

  assign w_send    = r_tvalid && m_axis_tready;
  assign w_pkt_in  = w_accept && w_last_in;
  assign w_pkt_out = w_send && r_tlast;

  assign w_q_last = w_rentry[ENTRY_WIDTH-1];
  assign w_q_strb = w_rentry[DATA_WIDTH +: STRB_WIDTH];
  assign w_q_data = w_rentry[DATA_WIDTH-1:0];

  // The RAM output always holds the word after the one being presented; it
  // is trustworthy only if that word was written before the read was issued,
  // i.e. the write pointer of one cycle ago is at least two words ahead.
  assign w_ahead = r_wr_ptr_d - r_rd_ptr;
  assign w_q_ok  = (w_ahead >= PW'(2));

`ifdef AXIS_PKT_BUFFER_CUT_THROUGH_EN
  assign w_start = (r_level != '0);
  assign w_more  = 1'b1;
`else
  assign w_start = (r_pkt_count != '0);
  assign w_more  = !r_tlast || (r_pkt_count > PW'(1));
`endif

  assign w_chain = w_more && w_q_ok;

  axis_pkt_ram #(
    .WIDTH (ENTRY_WIDTH),
    .AW    (ADDR_WIDTH)
  ) u_ram (
    .i_clk   (axis_aclk),
    .i_we    (w_accept),
    .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wdata (w_wentry),
    .i_raddr (w_raddr[ADDR_WIDTH-1:0]),
    .o_rdata (w_rentry)
  );

  // Ingress stays closed until the first clock after reset is released.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_ingress_on <= 1'b0;
    end else begin
      r_ingress_on <= 1'b1;
    end
  end

  // Write pointer, its one-cycle-old copy and the in-packet word counter.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_wr_ptr   <= '0;
      r_wr_ptr_d <= '0;
      r_in_cnt   <= '0;
    end else begin
      r_wr_ptr_d <= r_wr_ptr;
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_last_in) begin
          r_in_cnt <= '0;
        end else begin
          r_in_cnt <= r_in_cnt + CW'(1);
        end
      end
    end
  end

  // Stored-word and complete-packet counters; simultaneous ups and downs cancel.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_level     <= '0;
      r_pkt_count <= '0;
    end else begin
      case ({w_accept, w_send})
        2'b10:   r_level <= r_level + PW'(1);
        2'b01:   r_level <= r_level - PW'(1);
        default: r_level <= r_level;
      endcase
      case ({w_pkt_in, w_pkt_out})
        2'b10:   r_pkt_count <= r_pkt_count + PW'(1);
        2'b01:   r_pkt_count <= r_pkt_count - PW'(1);
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

  // Read pointer tracks the word currently presented on the master side.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_rd_ptr <= '0;
    end else if (w_send) begin
      r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // RAM read address: the head in IDLE, otherwise the word after the one
  // that will be presented next cycle, re-read every cycle so it stays fresh.
  always_comb begin
    w_raddr = r_rd_ptr;
    case (r_state)
      ST_IDLE:   w_raddr = r_rd_ptr;
      ST_FETCH:  w_raddr = r_rd_ptr + PW'(1);
      ST_STREAM: w_raddr = w_send ? (r_rd_ptr + PW'(2)) : (r_rd_ptr + PW'(1));
      default:   w_raddr = r_rd_ptr;
    endcase
  end

  // Egress FSM and master output registers; outputs only change on a
  // handshake or when a new word is loaded while tvalid is low.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_state  <= ST_IDLE;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tstrb  <= '0;
      r_tdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_tvalid <= 1'b1;
          r_tlast  <= w_q_last;
          r_tstrb  <= w_q_strb;
          r_tdata  <= w_q_data;
          r_state  <= ST_STREAM;
        end
        ST_STREAM: begin
          if (w_send) begin
            if (w_chain) begin
              r_tlast <= w_q_last;
              r_tstrb <= w_q_strb;
              r_tdata <= w_q_data;
            end else begin
              r_tvalid <= 1'b0;
              r_state  <= ST_IDLE;
            end
          end
        end
        default: begin
          r_tvalid <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tstrb  = r_tstrb;
  assign m_axis_tdata  = r_tdata;
  assign level         = r_level;
  assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_axis_pkt_buffer.sv
// Self-checking bench for axis_pkt_buffer (DATA_WIDTH=32, ADDR_WIDTH=4,
// MAX_PKT_LEN=8). Expected egress words are queued as ingress accepts them
// and compared as the DUT hands them out.
module tb_axis_pkt_buffer;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int MPL = 8;
  localparam int SW  = DW / 8;
  localparam int EW  = DW + SW + 1;

  logic          clk;
  logic          rst_n;
  logic          s_enable;
  logic [DW-1:0] s_tdata;
  logic [SW-1:0] s_tstrb;
  logic          s_tlast;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [AW:0]   level;
  logic [AW:0]   pkt_count;

  int total = 0;
  int bad   = 0;
  int in_cnt = 0;
  logic [EW-1:0] sb[$];

  logic          prev_hold = 1'b0;
  logic [EW-1:0] prev_word = '0;

  axis_pkt_buffer #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .MAX_PKT_LEN (MPL)
  ) dut (
    .axis_aclk     (clk),
    .axis_aresetn  (rst_n),
    .s_axis_enable (s_enable),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .level         (level),
    .pkt_count     (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Egress monitor: scoreboard compare on handshakes and stability while stalled.
  always @(negedge clk) begin
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    got = {m_tlast, m_tstrb, m_tdata};
    if (rst_n) begin
      if (prev_hold) begin
        total++;
        if (m_tvalid !== 1'b1 || got !== prev_word) begin
          bad++;
          $display("[TB] FAIL hold_stable: got valid=%b word=%h expected valid=1 word=%h",
                   m_tvalid, got, prev_word);
        end
      end
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_word: got %h expected no output", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            bad++;
            $display("[TB] FAIL egress_word: got %h expected %h", got, exp);
          end
        end
      end
      prev_hold = (m_tvalid === 1'b1) && (m_tready !== 1'b1);
      prev_word = got;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Offer one word and wait (bounded) for it to be accepted; queue the
  // expected egress entry with the bench's own forced-last rule.
  task automatic push_word(input logic [DW-1:0] d, input logic l);
    int n;
    logic exp_l;
    s_tdata  = d;
    s_tstrb  = d[SW-1:0] | 4'h1;
    s_tlast  = l;
    s_tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (s_tready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (s_tready !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL ingress_timeout: got tready=%b expected 1 for word %h", s_tready, d);
    end else begin
      exp_l = l || (in_cnt == MPL - 1);
      sb.push_back({exp_l, s_tstrb, d});
      in_cnt = exp_l ? 0 : in_cnt + 1;
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_drain: got %0d words pending expected 0", name, sb.size());
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_enable = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tdata = '0; s_tstrb = '0; m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({s_tready, m_tvalid, m_tlast, m_tdata, m_tstrb, level, pkt_count} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got tready=%b tvalid=%b tlast=%b tdata=%h tstrb=%h level=%0d pkts=%0d expected all 0",
               s_tready, m_tvalid, m_tlast, m_tdata, m_tstrb, level, pkt_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (s_tready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ready_after_reset: got %b expected 1", s_tready);
    end
    s_enable = 1'b0;
    #1;
    total++;
    if (s_tready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL enable_low: got tready=%b expected 0", s_tready);
    end
    s_enable = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    m_tready = 1'b1;
    push_word(32'hA0, 1'b0);
    push_word(32'hA1, 1'b0);
    push_word(32'hA2, 1'b1);
    total++;
    if (pkt_count !== 5'd1) begin
      bad++;
      $display("[TB] FAIL single_pkt_count: got %0d expected 1", pkt_count);
    end
`ifndef AXIS_PKT_BUFFER_CUT_THROUGH_EN
    total++;
    if (m_tvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_early_valid: got %b expected 0 at last accept", m_tvalid);
    end
    @(posedge clk);
    #1;
    total++;
    if (m_tvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_latency1: got tvalid=%b expected 0", m_tvalid);
    end
    @(posedge clk);
    #1;
    total++;
    if (m_tvalid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_latency2: got tvalid=%b expected 1", m_tvalid);
    end
`endif
    wait_drain("single");
    total++;
    if (pkt_count !== 5'd0 || level !== 5'd0) begin
      bad++;
      $display("[TB] FAIL single_empty: got pkts=%0d level=%0d expected 0 0", pkt_count, level);
    end
  endtask

  task automatic test_forced_last();
    int n;
    m_tready = 1'b1;
    for (int i = 0; i < 12; i++) push_word(32'hB0 + i, 1'b0);
`ifndef AXIS_PKT_BUFFER_CUT_THROUGH_EN
    n = 0;
    while (sb.size() > 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (level !== 5'd4 || pkt_count !== 5'd0 || m_tvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL forced_held: got level=%0d pkts=%0d tvalid=%b expected 4 0 0",
               level, pkt_count, m_tvalid);
    end
`endif
    push_word(32'hBC, 1'b1);
    wait_drain("forced");
  endtask

  task automatic test_back_to_back_full();
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) push_word(32'h100 + i, (i == 7) || (i == 15));
    total++;
    if (s_tready !== 1'b0 || level !== 5'd16 || pkt_count !== 5'd2) begin
      bad++;
      $display("[TB] FAIL full_state: got tready=%b level=%0d pkts=%0d expected 0 16 2",
               s_tready, level, pkt_count);
    end
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (s_tready !== 1'b1 || level !== 5'd15) begin
      bad++;
      $display("[TB] FAIL full_release: got tready=%b level=%0d expected 1 15", s_tready, level);
    end
    wait_drain("full");
    total++;
    if (pkt_count !== 5'd0) begin
      bad++;
      $display("[TB] FAIL full_pkt_count: got %0d expected 0", pkt_count);
    end
  endtask

  task automatic test_random_ready();
    m_tready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) push_word(32'hC0 + i, i == 4);
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1;
          m_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_tready = 1'b1;
    wait_drain("random");
    total++;
    if (level !== 5'd0 || pkt_count !== 5'd0) begin
      bad++;
      $display("[TB] FAIL random_empty: got level=%0d pkts=%0d expected 0 0", level, pkt_count);
    end
  endtask

  task automatic test_reset_mid();
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(32'hE0 + i, i == 3);
    total++;
    if (level !== 5'd6 || pkt_count !== 5'd1) begin
      bad++;
      $display("[TB] FAIL mid_state: got level=%0d pkts=%0d expected 6 1", level, pkt_count);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    in_cnt = 0;
    #1;
    total++;
    if ({s_tready, m_tvalid, m_tlast, m_tdata, m_tstrb, level, pkt_count} !== '0) begin
      bad++;
      $display("[TB] FAIL mid_reset_outputs: got tready=%b tvalid=%b tlast=%b tdata=%h tstrb=%h level=%0d pkts=%0d expected all 0",
               s_tready, m_tvalid, m_tlast, m_tdata, m_tstrb, level, pkt_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    push_word(32'hD0, 1'b0);
    push_word(32'hD1, 1'b1);
    wait_drain("after_reset");
    total++;
    if (level !== 5'd0 || pkt_count !== 5'd0) begin
      bad++;
      $display("[TB] FAIL after_reset_empty: got level=%0d pkts=%0d expected 0 0", level, pkt_count);
    end
  endtask

`ifdef AXIS_PKT_BUFFER_CUT_THROUGH_EN
  task automatic test_cut_through();
    m_tready = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) push_word(32'hF0 + i, i == 3);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!(s_tvalid === 1'b1 && s_tready === 1'b1) && n < 50) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk);
        #1;
        total++;
        if (m_tvalid !== 1'b0) begin
          bad++;
          $display("[TB] FAIL ct_latency0: got tvalid=%b expected 0", m_tvalid);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        total++;
        if (m_tvalid !== 1'b1 || pkt_count !== 5'd0) begin
          bad++;
          $display("[TB] FAIL ct_latency2: got tvalid=%b pkts=%0d expected 1 0", m_tvalid, pkt_count);
        end
      end
    join
    wait_drain("cut_through");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_forced_last();
    test_back_to_back_full();
    test_random_ready();
    test_reset_mid();
`ifdef AXIS_PKT_BUFFER_CUT_THROUGH_EN
    test_cut_through();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/axis_pkt_buffer.md
Name: axis_pkt_buffer

Overview:
- Single-clock, store-and-forward AXI-Stream packet buffer. It generalises the fixed memory-to-stream wrapper with parametrised width, depth and maximum packet length.
- Slave side writes words, tstrb and tlast into a circular RAM. The master side emits only complete packets, with correct tlast/tstrb.
- It sits between a stream producer and a downstream AXI-Stream consumer, absorbing backpressure.

Parameters:
- DATA_WIDTH, 32: tdata width in bits; must be a multiple of 8.
- ADDR_WIDTH, 12: RAM address width; DEPTH = 2**ADDR_WIDTH words.
- MAX_PKT_LEN, 256: longest packet in words; the block forces tlast at this length. Elaboration fails unless 1 <= MAX_PKT_LEN <= DEPTH.

Ports:
- axis_aclk  in  1  clock.
- axis_aresetn  in  1  reset, asynchronous, active-low.
- s_axis_enable  in  1  ingress enable; when low, tready is held low.
- s_axis_tdata  in  DATA_WIDTH  ingress data.
- s_axis_tstrb  in  DATA_WIDTH/8  ingress byte strobes.
- s_axis_tlast  in  1  ingress end of packet.
- s_axis_tvalid  in  1  ingress valid.
- s_axis_tready  out  1  ingress ready.
- m_axis_tdata  out  DATA_WIDTH  egress data.
- m_axis_tstrb  out  DATA_WIDTH/8  egress byte strobes.
- m_axis_tlast  out  1  egress end of packet.
- m_axis_tvalid  out  1  egress valid.
- m_axis_tready  in  1  egress ready.
- level  out  ADDR_WIDTH+1  words currently stored.
- pkt_count  out  ADDR_WIDTH+1  complete packets stored and not yet fully sent.

Behaviour:
- Reset (async assert, sync release): all of the following go to 0 — s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tstrb, level, pkt_count, pointers, in-packet word counter, FSM state.
  - Reset mid-operation discards all buffered and partial data.
- Storage: RAM entry holds {tlast, tstrb, tdata}. Read and write pointers are ADDR_WIDTH+1 bits and wrap modulo 2*DEPTH.
  - full = (level == DEPTH); empty = (level == 0).
- Ingress:
  - s_axis_tready = s_axis_enable && !full; combinational from registered state only.
  - Accept on tvalid && tready: write entry, increment write pointer and in-packet counter.
  - Stored tlast = s_axis_tlast OR (in-packet counter == MAX_PKT_LEN-1). A forced last restarts counting for the next word.
  - Accepting a last word resets the in-packet counter and increments pkt_count.
  - enable falling mid-packet only stalls ingress; the partial packet is kept.
- Egress FSM, states IDLE, FETCH, STREAM:
  - IDLE -> FETCH when pkt_count != 0. RAM has registered read: the address is issued in IDLE, data lands in FETCH.
  - FETCH -> STREAM: m_axis_tvalid=1 with the head word.
  - In STREAM, a handshake advances the read pointer. The next word is prefetched so throughput is 1 word/cycle while m_axis_tready=1.
  - STREAM -> IDLE after the handshake of a tlast word, which decrements pkt_count. Back-to-back packets go STREAM -> STREAM with no bubble if pkt_count > 1.
  - Output latency: first m_axis_tvalid no earlier than 2 cycles after the cycle accepting the packet's last word.
  - While tvalid && !tready, m_axis_tdata/tstrb/tlast are held stable. tvalid never drops before a handshake.
- Simultaneous accept and send: level unchanged. A simultaneous pkt_count increment and decrement nets zero.
- Full: tready drops in the cycle level reaches DEPTH and rises in the cycle after a send frees space.
  - No deadlock is possible: any DEPTH-word run contains a forced or real last.
- level and pkt_count are registered and reflect handshakes of the previous cycle.

Optional Feature:
- Macro AXIS_PKT_BUFFER_CUT_THROUGH_EN.
- Defined: the egress FSM leaves IDLE whenever level != 0, so words stream as soon as stored. First tvalid comes 2 cycles after the first accept. pkt_count is still maintained.
  - If egress reaches an unwritten word mid-packet, tvalid deasserts. This is the only case tvalid drops, and it occurs only between handshakes.
- Undefined: pure store-and-forward as above.

Decomposition:
- Package axis_pkt_pkg: FSM state enum {IDLE, FETCH, STREAM}; localparams STRB_WIDTH = DATA_WIDTH/8, ENTRY_WIDTH = DATA_WIDTH+STRB_WIDTH+1, DEPTH; clog2-based width helper.
- Sub-module axis_pkt_ram: simple dual-port RAM, one write port and one registered-read port, ENTRY_WIDTH x DEPTH, no reset on contents.

Test Plan:
- DATA_WIDTH=32, ADDR_WIDTH=4, MAX_PKT_LEN=8 for all scenarios.
- Single 3-word packet 0xA0..0xA2, tlast on word 3, m_tready=1 -> no m_tvalid until all 3 accepted; output 0xA0,0xA1,0xA2 with tlast on the third; pkt_count 1 -> 0.
- 12-word input with no tlast -> outputs 8-word packet (forced tlast on word 8). The remaining 4 words are held until a later s_tlast.
- m_tready=0 while feeding 16 words as two 8-word packets -> s_tready drops at level=16. Raising m_tready gives 16 words in order with tlast on words 8 and 16; s_tready returns next cycle.
- Random m_tready toggling on a 5-word packet -> tdata/tlast stable whenever tvalid && !tready; no word lost or duplicated.
- Reset asserted mid-stream (level=6, pkt_count=1) -> all outputs 0 immediately. After release, a new 2-word packet passes correctly.
- With AXIS_PKT_BUFFER_CUT_THROUGH_EN, a 4-word packet -> first m_tvalid 2 cycles after the first accept, before tlast is accepted.
